// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Latency: request sampled at edge N -> gnt in cycle N+1 -> rsp_valid in cycle N+2; one op per 3 cycles.
// Backpressure: none; a requester holds req/operands until its gnt pulse, and req is ignored while busy.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req0/a0/b0/op0           requester 0 request, operands, opcode
//   req1/a1/b1/op1           requester 1 request, operands, opcode
//   gnt0/gnt1                one-cycle pulse: operands of that requester accepted
//   rsp_valid0/rsp_valid1    one-cycle pulse: captured result belongs to that requester
//   rsp_data/zero/ovf/carry  captured ALU result and flags, held until the next capture
//   busy                     high whenever the arbiter is not idle
//   alu_a/alu_b/alu_op       registered operands/opcode to the external ALU
//   alu_res/zero/ovf/carry   result and flags from the external ALU
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_carry,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_d;
  logic             last_grant, last_grant_d;
  logic             cur, cur_d;          // requester owning the in-flight operation
  logic             win;
  logic             gnt0_d, gnt1_d, rsp_valid0_d, rsp_valid1_d, busy_d;
  logic [WIDTH-1:0] rsp_data_d, alu_a_d, alu_b_d;
  logic             rsp_zero_d, rsp_ovf_d, rsp_carry_d;
  logic [OPW-1:0]   alu_op_d;

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cur_d        = cur;
    win          = 1'b0;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    rsp_data_d   = rsp_data;
    rsp_zero_d   = rsp_zero;
    rsp_ovf_d    = rsp_ovf;
    rsp_carry_d  = rsp_carry;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = alu_op;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester not served last wins; otherwise the lone requester.
          win          = (req0 && req1) ? ~last_grant : req1;
          cur_d        = win;
          last_grant_d = win;
          gnt0_d       = ~win;
          gnt1_d       = win;
          alu_a_d      = win ? a1  : a0;
          alu_b_d      = win ? b1  : b0;
          alu_op_d     = win ? op1 : op0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable for a full cycle; take its result now.
        rsp_data_d   = alu_res;
        rsp_zero_d   = alu_zero;
        rsp_ovf_d    = alu_ovf;
        rsp_carry_d  = alu_carry;
        rsp_valid0_d = ~cur;
        rsp_valid1_d = cur;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_carry  <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      cur        <= cur_d;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      rsp_valid0 <= rsp_valid0_d;
      rsp_valid1 <= rsp_valid1_d;
      rsp_data   <= rsp_data_d;
      rsp_zero   <= rsp_zero_d;
      rsp_ovf    <= rsp_ovf_d;
      rsp_carry  <= rsp_carry_d;
      busy       <= busy_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a behavioural 8-bit ALU attached to its ALU ports.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [7:0] rsp_data;
  logic       rsp_zero, rsp_ovf, rsp_carry, busy;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_zero, alu_ovf, alu_carry;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_carry(rsp_carry),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry)
  );

  // External ALU: 000 add, 001 sub (carry = borrow), 010 and, 011 or, 100 xor, 101 pass B, 11x zero.
  always_comb begin
    logic [8:0] t;
    t         = 9'd0;
    alu_res   = 8'd0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (alu_op)
      3'b000: begin
        t         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res   = t[7:0];
        alu_carry = t[8];
        alu_ovf   = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      3'b001: begin
        t         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res   = t[7:0];
        alu_carry = t[8];
        alu_ovf   = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      3'b101:  alu_res = alu_b;
      default: alu_res = 8'd0;
    endcase
    alu_zero = (alu_res == 8'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       who;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] d;
    logic       z;
    logic       o;
    logic       c;
  } vec_t;

  vec_t vt[8];

  // Single operation on one requester, checking every cycle from grant to idle.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    if (v.who) begin req1 = 1'b1; a1 = v.a; b1 = v.b; op1 = v.op; end
    else       begin req0 = 1'b1; a0 = v.a; b0 = v.b; op0 = v.op; end
    @(negedge clk);  // EXEC
    chk("exec_gnt", 32'({gnt1, gnt0}), v.who ? 32'd2 : 32'd1);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rspv", 32'({rsp_valid1, rsp_valid0}), 32'd0);
    chk("exec_alu_in", 32'({alu_a, alu_b, alu_op}), 32'({v.a, v.b, v.op}));
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);  // RESP
    chk("resp_rspv", 32'({rsp_valid1, rsp_valid0}), v.who ? 32'd2 : 32'd1);
    chk("resp_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("resp_busy", 32'(busy), 32'd1);
    chk("resp_data", 32'(rsp_data), 32'(v.d));
    chk("resp_flags", 32'({rsp_zero, rsp_ovf, rsp_carry}), 32'({v.z, v.o, v.c}));
    @(negedge clk);  // back to IDLE
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rspv", 32'({rsp_valid1, rsp_valid0}), 32'd0);
    chk("idle_data_held", 32'(rsp_data), 32'(v.d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //         who   a      b      op     d      z     o     c
    vt[0] = '{1'b0, 8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 8'h00, 8'h01, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 8'h55, 8'hAA, 3'b110, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 8'h00, 8'h3C, 3'b101, 8'h3C, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 8'h0F, 8'hF0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; op0 = 3'b000;
    a1 = 8'h00; b1 = 8'h00; op1 = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        32'({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_zero, rsp_ovf, rsp_carry, busy}), 32'd0);
    chk("reset_data", 32'({rsp_data, alu_a, alu_b, alu_op}), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_op(vt[k]);

    // Both requesters held high: strict alternation starting with 0, grants 3 cycles apart.
    do_reset();
    a0 = 8'h10; b0 = 8'h20; op0 = 3'b000;  // 0x30
    a1 = 8'h50; b1 = 8'h05; op1 = 3'b001;  // 0x4B
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rr_gnt0", 32'(gnt0), 32'((i % 3 == 0) && ((i / 3) % 2 == 0)));
      chk("rr_gnt1", 32'(gnt1), 32'((i % 3 == 0) && ((i / 3) % 2 == 1)));
      if (i % 3 == 1) begin
        chk("rr_rspv", 32'({rsp_valid1, rsp_valid0}), ((i / 3) % 2 == 1) ? 32'd2 : 32'd1);
        chk("rr_data", 32'(rsp_data), ((i / 3) % 2 == 1) ? 32'h4B : 32'h30);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_quiet", 32'({gnt0, gnt1, busy}), 32'd0);

    // req0 streaming, req1 raised once while busy and held only until its own grant.
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("pulse_gnt0", 32'(gnt0), 32'((i % 3 == 0) && (i != 3)));
      chk("pulse_gnt1", 32'(gnt1), 32'(i == 3));
      if (i == 0) req1 = 1'b1;
      if (gnt1) req1 = 1'b0;
      if (i == 11) req0 = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Reset during EXEC drops the in-flight response and restores last_grant.
    @(negedge clk);
    req1 = 1'b1; a1 = 8'h11; b1 = 8'h22; op1 = 3'b000;
    @(negedge clk);
    chk("rst_exec_gnt1", 32'(gnt1), 32'd1);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    chk("rst_exec_outputs",
        32'({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_zero, rsp_ovf, rsp_carry, busy}), 32'd0);
    chk("rst_exec_data", 32'({rsp_data, alu_a, alu_b, alu_op}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_no_rspv", 32'({rsp_valid0, rsp_valid1, busy}), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("rst_then_gnt", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
